sdram_arbiter: RTL and testbench

Shares the single SDRAM controller port between the AVR core (data bus) and a video scanout fetcher. It sequences one access at a time, stalls the core through its ce input while a core access is pending, and holds the video requester off with a req/ack handshake. Video has priority, with a starvation guard that guarantees the core forward progress. A per-access timeout keeps a hung SDRAM from locking up the system.

---
 rtl/sdram_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between the AVR data bus and the video scanout fetcher.
// Video has priority, bounded by a burst limit while the core waits; every access has a timeout.
module sdram_arbiter #(
    parameter int VID_BURST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_data_o,
    output logic [7:0]  cpu_data_i,
    output logic        cpu_ce,
    input  logic        vid_req,
    input  logic [25:0] vid_address,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    output logic [25:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_data_o,
    input  logic [7:0]  mem_data_i,
    input  logic        mem_ready,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CPU_ACC = 2'd1,
        S_VID_ACC = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_VID = 1'b1
    } grant_t;

    localparam int            CW       = $clog2(VID_BURST + 1);
    localparam logic [CW-1:0] VID_MAX  = CW'(VID_BURST);
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    grant_t        last_grant_q, last_grant_d;
    logic [CW-1:0] vid_cnt_q, vid_cnt_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [25:0]   mem_address_q, mem_address_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [7:0]    mem_data_o_q, mem_data_o_d;
    logic [7:0]    cpu_data_i_q, cpu_data_i_d;
    logic [7:0]    vid_data_q, vid_data_d;
    logic          cpu_done_q, cpu_done_d;
    logic          vid_ack_q, vid_ack_d;
    logic          err_timeout_q, err_timeout_d;

    logic cpu_req_s;
    logic cpu_req_new_s;
    logic vid_win_s;

    assign cpu_req_s     = cpu_read | cpu_we;
    // The core still shows its old request during the cpu_done cycle; it is not a new access.
    assign cpu_req_new_s = cpu_req_s & ~cpu_done_q;
    assign vid_win_s     = vid_req & (~cpu_req_s | (vid_cnt_q < VID_MAX));

    // Next-state and output-register computation for the access sequencer.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        vid_cnt_d     = vid_cnt_q;
        tmo_d         = tmo_q;
        mem_address_d = mem_address_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_data_o_d  = mem_data_o_q;
        cpu_data_i_d  = cpu_data_i_q;
        vid_data_d    = vid_data_q;
        cpu_done_d    = 1'b0;
        vid_ack_d     = 1'b0;
        err_timeout_d = err_timeout_q;

        case (state_q)
            S_IDLE: begin
                tmo_d = 8'd0;
                if (vid_win_s) begin
                    state_d       = S_VID_ACC;
                    last_grant_d  = GRANT_VID;
                    mem_address_d = vid_address;
                    mem_read_d    = 1'b1;
                    mem_write_d   = 1'b0;
                    // Only grants that make the core wait count towards the burst limit.
                    if (cpu_req_s) begin
                        vid_cnt_d = vid_cnt_q + CW'(1);
                    end else begin
                        vid_cnt_d = {CW{1'b0}};
                    end
                end else if (cpu_req_new_s) begin
                    state_d       = S_CPU_ACC;
                    last_grant_d  = GRANT_CPU;
                    mem_address_d = {10'b0, cpu_address};
                    mem_data_o_d  = cpu_data_o;
                    mem_write_d   = cpu_we;
                    mem_read_d    = ~cpu_we;
                    vid_cnt_d     = {CW{1'b0}};
                end else if (!cpu_req_s) begin
                    vid_cnt_d = {CW{1'b0}};
                end else begin
                    vid_cnt_d = vid_cnt_q;
                end
            end

            S_CPU_ACC: begin
                tmo_d = tmo_q + 8'd1;
                if (mem_ready) begin
                    state_d     = S_IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    cpu_done_d  = 1'b1;
                    if (mem_read_q) begin
                        cpu_data_i_d = mem_data_i;
                    end else begin
                        cpu_data_i_d = cpu_data_i_q;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d       = S_IDLE;
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    cpu_done_d    = 1'b1;
                    err_timeout_d = 1'b1;
                    if (mem_read_q) begin
                        cpu_data_i_d = 8'hFF;
                    end else begin
                        cpu_data_i_d = cpu_data_i_q;
                    end
                end else begin
                    state_d = S_CPU_ACC;
                end
            end

            S_VID_ACC: begin
                tmo_d = tmo_q + 8'd1;
                if (mem_ready) begin
                    state_d    = S_IDLE;
                    mem_read_d = 1'b0;
                    vid_ack_d  = 1'b1;
                    vid_data_d = mem_data_i;
                end else if (tmo_q == TMO_LAST) begin
                    state_d       = S_IDLE;
                    mem_read_d    = 1'b0;
                    vid_ack_d     = 1'b1;
                    vid_data_d    = 8'hFF;
                    err_timeout_d = 1'b1;
                end else begin
                    state_d = S_VID_ACC;
                end
            end

            default: begin
                state_d     = S_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset returns everything to an idle, error-free port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= GRANT_VID;
            vid_cnt_q     <= {CW{1'b0}};
            tmo_q         <= 8'd0;
            mem_address_q <= 26'd0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_data_o_q  <= 8'd0;
            cpu_data_i_q  <= 8'd0;
            vid_data_q    <= 8'd0;
            cpu_done_q    <= 1'b0;
            vid_ack_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            vid_cnt_q     <= vid_cnt_d;
            tmo_q         <= tmo_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_data_o_q  <= mem_data_o_d;
            cpu_data_i_q  <= cpu_data_i_d;
            vid_data_q    <= vid_data_d;
            cpu_done_q    <= cpu_done_d;
            vid_ack_q     <= vid_ack_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign cpu_ce      = ~cpu_req_s | cpu_done_q;
    assign cpu_data_i  = cpu_data_i_q;
    assign vid_ack     = vid_ack_q;
    assign vid_data    = vid_data_q;
    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_data_o  = mem_data_o_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a small SDRAM responder with programmable latency,
// a grant logger, and one task per scenario with hand-computed expectations.
module tb_sdram_arbiter;

    localparam logic [25:0] VADDR = 26'h3ABCDE0;

    logic        clock;
    logic        reset_n;
    logic [15:0] cpu_address;
    logic        cpu_read;
    logic        cpu_we;
    logic [7:0]  cpu_data_o;
    logic [7:0]  cpu_data_i;
    logic        cpu_ce;
    logic        vid_req;
    logic [25:0] vid_address;
    logic        vid_ack;
    logic [7:0]  vid_data;
    logic [25:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_data_o;
    logic [7:0]  mem_data_i;
    logic        mem_ready;
    logic        err_timeout;

    int   n_cmp;
    int   n_fail;
    int   mem_lat;
    logic [7:0] mem_rdata;
    bit   resp_en;
    bit   ready_poke;
    bit   log_en;
    int   cmd_rise;
    logic grants[$];

    sdram_arbiter #(.VID_BURST(4), .TIMEOUT(255)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_address (cpu_address),
        .cpu_read    (cpu_read),
        .cpu_we      (cpu_we),
        .cpu_data_o  (cpu_data_o),
        .cpu_data_i  (cpu_data_i),
        .cpu_ce      (cpu_ce),
        .vid_req     (vid_req),
        .vid_address (vid_address),
        .vid_ack     (vid_ack),
        .vid_data    (vid_data),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ready   (mem_ready),
        .err_timeout (err_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // SDRAM model: mem_ready pulses once the command has been seen for mem_lat cycles.
    initial begin
        int cnt;
        cnt        = 0;
        mem_ready  = 1'b0;
        mem_data_i = 8'h00;
        forever begin
            @(posedge clock);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (ready_poke) begin
                mem_ready  = 1'b1;
                mem_data_i = 8'hEE;
                ready_poke = 1'b0;
            end else if ((mem_read || mem_write) && resp_en) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_ready  = 1'b1;
                    mem_data_i = mem_rdata;
                    cnt        = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Grant logger: 1 = video, 0 = CPU, one entry per new command.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if ((mem_read || mem_write) && !prev) begin
                cmd_rise++;
                if (log_en) grants.push_back(mem_address == VADDR);
            end
            prev = mem_read || mem_write;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; cpu_read = 1'b0; cpu_we = 1'b0; vid_req = 1'b0;
        cpu_address = 16'h0000; cpu_data_o = 8'h00; vid_address = 26'h0;
        repeat (3) @(negedge clock);
        n_cmp++; if (cpu_ce !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_ce: got %b want 1", cpu_ce); end
        n_cmp++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_cmd: got rd=%b wr=%b want 0 0", mem_read, mem_write); end
        n_cmp++; if (vid_ack !== 1'b0) begin n_fail++; $display("FAIL reset_vid_ack: got %b want 0", vid_ack); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        n_cmp++; if (cpu_data_i !== 8'h00 || vid_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h %h want 00 00", cpu_data_i, vid_data); end
        n_cmp++; if (mem_address !== 26'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_address); end
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b want 0", mem_read); end
    endtask

    task automatic test_cpu_read();
        int ce_low, rd_hi, rises0;
        bit done;
        ce_low = 0; rd_hi = 0; done = 1'b0;
        mem_lat = 2; mem_rdata = 8'h5A; rises0 = cmd_rise;
        @(posedge clock); #1;
        cpu_address = 16'h0100; cpu_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cpu_ce) begin done = 1'b1; break; end
            ce_low++;
            if (mem_read) begin
                rd_hi++;
                n_cmp++; if (mem_address !== 26'h0000100) begin n_fail++; $display("FAIL rd_addr: got %h want 0000100", mem_address); end
            end
        end
        n_cmp++; if (!done) begin n_fail++; $display("FAIL rd_done: got no cpu_done want one within 20 cycles"); end
        n_cmp++; if (ce_low != 3) begin n_fail++; $display("FAIL rd_ce_low: got %0d want 3", ce_low); end
        n_cmp++; if (rd_hi != 2) begin n_fail++; $display("FAIL rd_cmd_len: got %0d want 2", rd_hi); end
        n_cmp++; if (cpu_data_i !== 8'h5A) begin n_fail++; $display("FAIL rd_data: got %h want 5a", cpu_data_i); end
        n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL rd_drop: got %b want 0", mem_read); end
        @(posedge clock); #1;
        cpu_read = 1'b0;
        @(negedge clock);
        n_cmp++; if (mem_read !== 1'b0 || cpu_ce !== 1'b1) begin n_fail++; $display("FAIL rd_no_regrant: got rd=%b ce=%b want 0 1", mem_read, cpu_ce); end
        n_cmp++; if (cmd_rise - rises0 != 1) begin n_fail++; $display("FAIL rd_count: got %0d want 1", cmd_rise - rises0); end
    endtask

    task automatic test_cpu_write();
        int wr_hi, rd_seen;
        bit done;
        wr_hi = 0; rd_seen = 0; done = 1'b0; mem_lat = 3;
        @(posedge clock); #1;
        cpu_address = 16'h0200; cpu_data_o = 8'hC3; cpu_we = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cpu_ce) begin done = 1'b1; break; end
            if (mem_read) rd_seen++;
            if (mem_write) begin
                wr_hi++;
                n_cmp++; if (mem_data_o !== 8'hC3 || mem_address !== 26'h0000200) begin n_fail++; $display("FAIL wr_bus: got %h/%h want c3/0000200", mem_data_o, mem_address); end
            end
        end
        n_cmp++; if (!done) begin n_fail++; $display("FAIL wr_done: got no cpu_done want one within 20 cycles"); end
        n_cmp++; if (wr_hi != 3 || rd_seen != 0) begin n_fail++; $display("FAIL wr_cmd_len: got wr=%0d rd=%0d want 3 0", wr_hi, rd_seen); end
        n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL wr_drop: got %b want 0", mem_write); end
        n_cmp++; if (cpu_data_i !== 8'h5A) begin n_fail++; $display("FAIL wr_keeps_data: got %h want 5a", cpu_data_i); end
        @(negedge clock);
        n_cmp++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL wr_ce_one_cycle: got %b want 0", cpu_ce); end
        cpu_we = 1'b0;
        @(negedge clock);
        n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got %b want 0", mem_write); end
    endtask

    task automatic test_idle_ready();
        ready_poke = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_cmp++; if (cpu_data_i !== 8'h5A || vid_data !== 8'h00) begin n_fail++; $display("FAIL idle_ready_data: got %h %h want 5a 00", cpu_data_i, vid_data); end
        n_cmp++; if (vid_ack !== 1'b0 || mem_read !== 1'b0 || cpu_ce !== 1'b1) begin n_fail++; $display("FAIL idle_ready_ctl: got ack=%b rd=%b ce=%b want 0 0 1", vid_ack, mem_read, cpu_ce); end
    endtask

    task automatic test_priority();
        logic exp_g [10];
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        mem_lat = 2; mem_rdata = 8'h11;
        grants.delete(); log_en = 1'b1;
        @(posedge clock); #1;
        vid_address = VADDR; vid_req = 1'b1; cpu_address = 16'h0300; cpu_read = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (grants.size() >= 10 && cpu_ce) break;
        end
        vid_req = 1'b0; cpu_read = 1'b0; log_en = 1'b0;
        n_cmp++; if (grants.size() != 10) begin n_fail++; $display("FAIL prio_count: got %0d want 10", grants.size()); end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (k >= grants.size() || grants[k] !== exp_g[k]) begin
                n_fail++;
                $display("FAIL prio_grant%0d: got %b want %b", k, (k < grants.size()) ? grants[k] : 1'bx, exp_g[k]);
            end
        end
        @(negedge clock);
        n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %b want 0", mem_read); end
    endtask

    task automatic test_simultaneous();
        int acks;
        acks = 0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        mem_lat = 2; mem_rdata = 8'h3C; grants.delete(); log_en = 1'b1;
        @(posedge clock); #1;
        vid_address = VADDR; vid_req = 1'b1; cpu_address = 16'h0042; cpu_read = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (vid_ack) begin acks++; vid_req = 1'b0; end
            if (cpu_ce) break;
        end
        cpu_read = 1'b0; log_en = 1'b0;
        n_cmp++; if (grants.size() != 2) begin n_fail++; $display("FAIL simul_count: got %0d want 2", grants.size()); end
        n_cmp++; if (grants.size() < 2 || grants[0] !== 1'b1 || grants[1] !== 1'b0) begin n_fail++; $display("FAIL simul_order: got size %0d want video then cpu", grants.size()); end
        n_cmp++; if (acks != 1) begin n_fail++; $display("FAIL simul_acks: got %0d want 1", acks); end
        n_cmp++; if (vid_data !== 8'h3C || cpu_data_i !== 8'h3C) begin n_fail++; $display("FAIL simul_data: got %h %h want 3c 3c", vid_data, cpu_data_i); end
    endtask

    task automatic test_timeout();
        int rd_hi;
        bit done;
        rd_hi = 0; done = 1'b0;
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_pre: got %b want 0", err_timeout); end
        resp_en = 1'b0;
        @(posedge clock); #1;
        cpu_address = 16'h0400; cpu_read = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (cpu_ce) begin done = 1'b1; break; end
            if (mem_read) rd_hi++;
        end
        cpu_read = 1'b0;
        n_cmp++; if (!done) begin n_fail++; $display("FAIL tmo_done: got no cpu_done want one within 400 cycles"); end
        n_cmp++; if (rd_hi != 255) begin n_fail++; $display("FAIL tmo_len: got %0d want 255", rd_hi); end
        n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", err_timeout); end
        n_cmp++; if (cpu_data_i !== 8'hFF) begin n_fail++; $display("FAIL tmo_data: got %h want ff", cpu_data_i); end
        n_cmp++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL tmo_drop: got %b want 0", mem_read); end
        resp_en = 1'b1; mem_lat = 2; mem_rdata = 8'h77; done = 1'b0;
        @(posedge clock); #1;
        cpu_address = 16'h0500; cpu_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cpu_ce) begin done = 1'b1; break; end
        end
        cpu_read = 1'b0;
        n_cmp++; if (!done || cpu_data_i !== 8'h77) begin n_fail++; $display("FAIL tmo_after: got done=%b data=%h want 1 77", done, cpu_data_i); end
        n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", err_timeout); end
    endtask

    task automatic test_reset_mid();
        int acks, rd_hi;
        acks = 0; rd_hi = 0;
        mem_lat = 10; mem_rdata = 8'h99;
        @(posedge clock); #1;
        vid_address = VADDR; vid_req = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL mid_in_access: got %b want 1", mem_read); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (mem_read !== 1'b0 || vid_ack !== 1'b0) begin n_fail++; $display("FAIL mid_async_cmd: got rd=%b ack=%b want 0 0", mem_read, vid_ack); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL mid_async_err: got %b want 0", err_timeout); end
        vid_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        mem_lat = 2;
        @(posedge clock); #1;
        vid_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_read) rd_hi++;
            if (vid_ack) begin acks++; vid_req = 1'b0; break; end
        end
        vid_req = 1'b0;
        n_cmp++; if (acks != 1) begin n_fail++; $display("FAIL mid_after_ack: got %0d want 1", acks); end
        n_cmp++; if (vid_data !== 8'h99) begin n_fail++; $display("FAIL mid_after_data: got %h want 99", vid_data); end
        n_cmp++; if (rd_hi != 2) begin n_fail++; $display("FAIL mid_after_len: got %0d want 2", rd_hi); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cmd_rise = 0;
        mem_lat = 2; mem_rdata = 8'h00; resp_en = 1'b1; ready_poke = 1'b0; log_en = 1'b0;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_idle_ready();
        test_priority();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
